cla_serial_adder: RTL and testbench
===================================

// Module: cla_serial_adder
// PURPOSE
//  Multi-cycle WIDTH-bit adder built around one cla4 slice (ports a,b,cin,cout,y).
//  Adds one 4-bit nibble per clock, LSB nibble first, and registers the ripple carry
//  between cycles. Upstream uses a valid/ready handshake to present operands;
//  downstream consumes the sum with a second valid/ready handshake.
// PARAMETERS
//  WIDTH   16   operand/sum width in bits; must be a multiple of 4 and >= 4
//  NIB     WIDTH/4 (localparam)  number of cla4 passes per operation
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands a,b,cin valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  operand A, sampled on accept
//  b          in   WIDTH  operand B, sampled on accept
//  cin        in   1      carry-in, sampled on accept
//  out_valid  out  1      sum/cout valid (high only in DONE)
//  out_ready  in   1      downstream takes result
//  y          out  WIDTH  sum
//  cout       out  1      carry out of bit WIDTH-1
//  ovf        out  1      signed overflow (only with CLA_SERIAL_OVF_EN)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, nibble counter=0, carry reg=0, operand regs=0,
//    y=0, cout=0, ovf=0, out_valid=0, in_ready=1 once rst_n releases. Reset during ADD
//    or DONE aborts the operation; the partial result is discarded.
//  - FSM states IDLE, ADD, DONE:
//    IDLE: in_ready=1. On edge with in_valid=1: latch a,b; carry reg<=cin; cnt<=0; y<=0;
//          go to ADD. in_valid=0 -> stay in IDLE.
//    ADD:  in_ready=0. Each edge: cla4 gets a[4cnt+:4], b[4cnt+:4] and the carry reg;
//          y[4cnt+:4]<=slice sum; carry reg<=slice cout; cnt<=cnt+1. On the edge that
//          processes cnt=NIB-1: cout<=slice cout, go to DONE.
//    DONE: out_valid=1; y/cout/ovf stable. Edge with out_ready=1 -> IDLE (out_valid=0
//          after that edge). out_ready=0 -> hold indefinitely (backpressure).
//  - Latency: out_valid rises NIB edges after the accept edge (WIDTH=16: 4 edges).
//    Minimum initiation interval NIB+2 cycles. The block never accepts new operands in
//    the same cycle a result leaves (in_ready=0 in DONE).
//  - in_valid during ADD/DONE is ignored; the upstream must hold operands until in_ready.
//  - Arithmetic: {cout,y} = a + b + cin, modulo 2^(WIDTH+1); no saturation. Counter
//    width $clog2(NIB) with a minimum of 1 bit; cnt never exceeds NIB-1.
//  - out_ready while not in DONE has no effect.
// CONFIGURATION
//  CLA_SERIAL_OVF_EN defined: port ovf exists; on the final ADD edge
//    ovf <= (a[W-1]==b[W-1]) && (slice sum MSB != a[W-1]); valid with out_valid.
//  CLA_SERIAL_OVF_EN undefined: the ovf port and its logic are removed; all other
//    behaviour is identical.
// TESTING (WIDTH=16)
//  1. a=16'h1234, b=16'h4321, cin=0 -> after 4 ADD edges y=16'h5555, cout=0, out_valid=1.
//  2. a=16'hFFFF, b=16'h0001, cin=0 -> y=16'h0000, cout=1 (carry ripples across all nibbles).
//  3. [OVF_EN] a=16'h7FFF, b=16'h0001, cin=0 -> y=16'h8000, cout=0, ovf=1;
//     a=16'h8000, b=16'h8000, cin=0 -> y=0, cout=1, ovf=1; 16'h0003+16'h0004, cin=1 -> y=8, ovf=0.
//  4. Backpressure: hold out_ready=0 for 10 cycles in DONE -> y/cout stable, in_ready=0;
//     drive a new in_valid meanwhile -> ignored; release out_ready -> IDLE, then accept.
//  5. Reset mid-op: pulse rst_n low after the 2nd ADD edge -> out_valid=0, y=0 immediately
//     (async); the next op 16'h00FF+16'h0001, cin=0 -> y=16'h0100, cout=0.
//  6. Back-to-back random ops (>=1000) with a,b,cin random and out_ready random -> every
//     result matches a+b+cin; one result per accepted operand set, in order.

Source files
------------

// File: rtl/cla_serial_adder.sv
// Nibble-serial WIDTH-bit adder: one 4-bit carry-lookahead slice per clock, LSB nibble first.
// Optional signed-overflow output enabled by defining CLA_SERIAL_OVF_EN.
module cla_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] y_o,
  output logic             cout_o
`ifdef CLA_SERIAL_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned CntW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic              cout_q, cout_d;
  logic [3:0]        nib_a, nib_b, g, p, sum;
  logic [4:0]        c;
  logic              last;

  // Select the operand nibble addressed by the counter.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (cnt_q == CntW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  // 4-bit carry-lookahead slice.
  always_comb begin
    g    = nib_a & nib_b;
    p    = nib_a ^ nib_b;
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum  = p ^ c[3:0];
  end

  assign last = (cnt_q == CntW'(NIB - 1));

`ifdef CLA_SERIAL_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    y_d         = y_q;
    cout_d      = cout_q;
`ifdef CLA_SERIAL_OVF_EN
    ovf_d       = ovf_q;
`endif
    in_ready_o  = (state_q == StIdle);
    out_valid_o = (state_q == StDone);
    case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = cin_i;
          cnt_d   = '0;
          y_d     = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        for (int unsigned i = 0; i < NIB; i++) begin
          if (cnt_q == CntW'(i)) y_d[4*i +: 4] = sum;
        end
        carry_d = c[4];
        if (last) begin
          cout_d  = c[4];
`ifdef CLA_SERIAL_OVF_EN
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[3] != a_q[WIDTH-1]);
`endif
          // Counter parks at zero so it never exceeds NIB-1.
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      cout_q  <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
`ifdef CLA_SERIAL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign y_o    = y_q;
  assign cout_o = cout_q;
`ifdef CLA_SERIAL_OVF_EN
  assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_serial_adder.sv
// Bench for cla_serial_adder (WIDTH=16): vector table, backpressure, mid-op reset and
// random traffic, with results checked against a queue of expected sums.
module tb_cla_serial_adder;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [W-1:0] a, b, y;
`ifdef CLA_SERIAL_OVF_EN
  logic         ovf;
`endif

  cla_serial_adder #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_i        (a),
    .b_i        (b),
    .cin_i      (cin),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .y_o        (y),
    .cout_o     (cout)
`ifdef CLA_SERIAL_OVF_EN
    ,
    .ovf_o      (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] y;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] y;
    logic         cout;
    logic         ovf;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   rnd      = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Compares a result on the cycle its output handshake completes.
  task automatic mon();
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_result: got y=%h cout=%b expected none", y, cout);
      end else begin
        e = sb.pop_front();
        check("y", 32'(y), 32'(e.y));
        check("cout", 32'(cout), 32'(e.cout));
`ifdef CLA_SERIAL_OVF_EN
        check("ovf", 32'(ovf), 32'(e.ovf));
`endif
      end
    end
  endtask

  // Inputs are driven at the falling edge; one step passes one rising edge.
  task automatic step();
    mon();
    @(negedge clk);
  endtask

  task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                       input logic [W-1:0] ey, input logic ec, input logic eo, input bit lat);
    exp_t e;
    int   guard;
    bit   early;
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    cin      = vc;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      step();
      guard++;
    end
    if (!in_ready) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
      in_valid = 1'b0;
      return;
    end
    e.y    = ey;
    e.cout = ec;
    e.ovf  = eo;
    sb.push_back(e);
    step();
    in_valid = 1'b0;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
    if (lat) begin
      early = 1'b0;
      for (int k = 1; k <= int'(NIB); k++) begin
        step();
        if (k < int'(NIB)) early = early | out_valid;
      end
      check("latency", 32'({early, out_valid}), 32'(2'b01));
    end
  endtask

  initial begin
    vec_t         vecs[8];
    logic [W-1:0] snap_y;
    logic         snap_c;
    logic [W:0]   full;
    logic [W-1:0] ra, rb;
    logic         rc;
    int           guard;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h0003, 16'h0004, 1'b1, 16'h0008, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
`ifdef CLA_SERIAL_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with latency check.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].y, vecs[i].cout, vecs[i].ovf, 1'b1);
    end
    step();

    // Backpressure: result must hold and new operands must be ignored.
    out_ready = 1'b0;
    do_op(16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0, 1'b0, 1'b1);
    snap_y   = y;
    snap_c   = cout;
    check("bp_snap_y", 32'(snap_y), 32'h3334);
    in_valid = 1'b1;
    a        = 16'hDEAD;
    b        = 16'hBEEF;
    cin      = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("bp_hold", 32'({y, cout, in_ready, out_valid}), 32'({snap_y, snap_c, 1'b0, 1'b1}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    do_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
    step();

    // Reset after the second ADD edge aborts the operation.
    in_valid = 1'b1;
    a        = 16'hFFFF;
    b        = 16'hFFFF;
    cin      = 1'b0;
    check("rst_mid_accept_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    step();
    step();
    check("rst_mid_partial", 32'(y), 32'h00FE);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_y", 32'(y), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);

    // Random back-to-back traffic with random backpressure.
    rnd = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rc   = 1'($urandom_range(0, 1));
      full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      do_op(ra, rb, rc, full[W-1:0], full[W],
            (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]), 1'b0);
    end
    rnd       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard     = 0;
    while (sb.size() > 0 && guard < 100) begin
      step();
      guard++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
